// File: rtl/st_dispatch_2.sv
// 1-to-2 stream dispatcher: round-robin packet steering onto two registered
// output lanes, with per-lane packet counters and a protocol-error counter.
module st_dispatch_2 #(
  parameter int DWIDTH      = 8,
  parameter int USE_PACKETS = 1,
  parameter int CWIDTH      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic [DWIDTH-1:0] out_data_0,
  output logic [DWIDTH-1:0] out_data_1,
  output logic              out_valid_0,
  output logic              out_valid_1,
  input  logic              out_ready_0,
  input  logic              out_ready_1,
  output logic              out_sop_0,
  output logic              out_sop_1,
  output logic              out_eop_0,
  output logic              out_eop_1,
  output logic [CWIDTH-1:0] pkt_cnt_0,
  output logic [CWIDTH-1:0] pkt_cnt_1,
  output logic [CWIDTH-1:0] err_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]                   st_q, st_d;
  logic                         rr_q, rr_d;
  logic                         lock_q, lock_d;
  logic [1:0]                   vld_q, vld_d;
  logic [1:0]                   sop_q, sop_d;
  logic [1:0]                   eop_q, eop_d;
  logic [1:0][DWIDTH-1:0]       dat_q, dat_d;
  logic [1:0][CWIDTH-1:0]       pkt_q, pkt_d;
  logic [CWIDTH-1:0]            err_q, err_d;

  logic [1:0] out_rdy;
  logic [1:0] can_acc;
  logic [1:0] ld;
  logic       beat_sop, beat_eop;
  logic       target;
  logic       rdy;
  logic       acc;
  logic       viol;

  assign out_rdy = {out_ready_1, out_ready_0};
  assign can_acc = ~vld_q | out_rdy;

  always_comb begin
    beat_sop = (USE_PACKETS != 0) ? in_sop : 1'b1;
    beat_eop = (USE_PACKETS != 0) ? in_eop : 1'b1;

    // IDLE prefers rr and falls back to the other lane; LOCKED is pinned.
    if (st_q == ST_IDLE) begin
      target = can_acc[rr_q] ? rr_q : ~rr_q;
      rdy    = |can_acc;
    end else begin
      target = lock_q;
      rdy    = can_acc[lock_q];
    end

    acc  = in_valid & rdy;
    ld   = {acc & target, acc & ~target};
    viol = acc & (((st_q == ST_IDLE) & ~beat_sop) | ((st_q == ST_LOCKED) & beat_sop));

    st_d   = st_q;
    rr_d   = rr_q;
    lock_d = lock_q;
    vld_d  = vld_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    dat_d  = dat_q;
    pkt_d  = pkt_q;
    err_d  = err_q;

    for (int unsigned k = 0; k < 2; k++) begin
      if (ld[k]) begin
        vld_d[k] = 1'b1;
        dat_d[k] = in_data;
        // Delimiters follow the FSM, which repairs malformed sop.
        sop_d[k] = (st_q == ST_IDLE);
        eop_d[k] = beat_eop;
        if (beat_eop) pkt_d[k] = pkt_q[k] + CWIDTH'(1);
      end else if (out_rdy[k]) begin
        vld_d[k] = 1'b0;
      end
    end

    if (viol && (err_q != '1)) err_d = err_q + CWIDTH'(1);

    if (acc) begin
      if (st_q == ST_IDLE) begin
        rr_d = ~target;
        if (!beat_eop) begin
          lock_d = target;
          st_d   = ST_LOCKED;
        end
      end else if (beat_eop) begin
        st_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= ST_IDLE;
      rr_q   <= 1'b0;
      lock_q <= 1'b0;
      vld_q  <= '0;
      sop_q  <= '0;
      eop_q  <= '0;
      dat_q  <= '0;
      pkt_q  <= '0;
      err_q  <= '0;
    end else begin
      st_q   <= st_d;
      rr_q   <= rr_d;
      lock_q <= lock_d;
      vld_q  <= vld_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      dat_q  <= dat_d;
      pkt_q  <= pkt_d;
      err_q  <= err_d;
    end
  end

  assign in_ready    = rdy;
  assign out_valid_0 = vld_q[0];
  assign out_valid_1 = vld_q[1];
  assign out_data_0  = dat_q[0];
  assign out_data_1  = dat_q[1];
  assign out_sop_0   = sop_q[0];
  assign out_sop_1   = sop_q[1];
  assign out_eop_0   = eop_q[0];
  assign out_eop_1   = eop_q[1];
  assign pkt_cnt_0   = pkt_q[0];
  assign pkt_cnt_1   = pkt_q[1];
  assign err_cnt     = err_q;

endmodule

// File: tb/tb_st_dispatch_2.sv
// Directed bench for st_dispatch_2: per-lane scoreboard queues filled at drive
// time and drained by a lane monitor on the falling clock edge.
module tb_st_dispatch_2;

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic        in_eop;
  logic [7:0]  out_data_0, out_data_1;
  logic        out_valid_0, out_valid_1;
  logic        out_ready_0, out_ready_1;
  logic        out_sop_0, out_sop_1;
  logic        out_eop_0, out_eop_1;
  logic [31:0] pkt_cnt_0, pkt_cnt_1, err_cnt;

  int checks   = 0;
  int failures = 0;

  // Entry layout: {sop, eop, data}
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  st_dispatch_2 #(.DWIDTH(8), .USE_PACKETS(1), .CWIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_data_0(out_data_0), .out_data_1(out_data_1),
    .out_valid_0(out_valid_0), .out_valid_1(out_valid_1),
    .out_ready_0(out_ready_0), .out_ready_1(out_ready_1),
    .out_sop_0(out_sop_0), .out_sop_1(out_sop_1),
    .out_eop_0(out_eop_0), .out_eop_1(out_eop_1),
    .pkt_cnt_0(pkt_cnt_0), .pkt_cnt_1(pkt_cnt_1), .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (out_valid_0 && out_ready_0) begin
        if (q0.size() == 0) chk("lane0_unexpected", {22'd0, out_sop_0, out_eop_0, out_data_0}, 32'hFFFF_FFFF);
        else chk("lane0_beat", {22'd0, out_sop_0, out_eop_0, out_data_0}, {22'd0, q0.pop_front()});
      end
      if (out_valid_1 && out_ready_1) begin
        if (q1.size() == 0) chk("lane1_unexpected", {22'd0, out_sop_1, out_eop_1, out_data_1}, 32'hFFFF_FFFF);
        else chk("lane1_beat", {22'd0, out_sop_1, out_eop_1, out_data_1}, {22'd0, q1.pop_front()});
      end
    end
  end

  // Offer one beat, expect immediate acceptance; returns 1 time unit after the edge.
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e,
                           input logic lane, input logic exp_sop);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    if (lane) q1.push_back({exp_sop, e, d});
    else      q0.push_back({exp_sop, e, d});
    @(negedge clk);
    chk("in_ready_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (((q0.size() != 0) || (q1.size() != 0)) && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", q0.size() + q1.size(), 32'd0);
  endtask

  initial begin
    reset_n     = 1'b0;
    in_data     = '0;
    in_valid    = 1'b0;
    in_sop      = 1'b0;
    in_eop      = 1'b0;
    out_ready_0 = 1'b1;
    out_ready_1 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {30'd0, out_valid_1, out_valid_0}, 32'd0);
    chk("rst_data", {16'd0, out_data_1, out_data_0}, 32'd0);
    chk("rst_delim", {28'd0, out_sop_1, out_eop_1, out_sop_0, out_eop_0}, 32'd0);
    chk("rst_pkt0", pkt_cnt_0, 32'd0);
    chk("rst_pkt1", pkt_cnt_1, 32'd0);
    chk("rst_err", err_cnt, 32'd0);
    reset_n = 1'b1;

    // Single-beat packets alternate lanes, visible right after the accepting edge.
    for (int i = 1; i <= 6; i++) begin
      send_beat(8'(i), 1'b1, 1'b1, 1'(i % 2 == 0), 1'b1);
      if (i % 2 == 1) begin
        chk("t1_lat_v", {30'd0, out_valid_1, out_valid_0}, 32'd1);
        chk("t1_lat_d", {24'd0, out_data_0}, 32'(i));
      end else begin
        chk("t1_lat_v", {30'd0, out_valid_1, out_valid_0}, 32'd2);
        chk("t1_lat_d", {24'd0, out_data_1}, 32'(i));
      end
    end
    drain();
    chk("t1_pkt0", pkt_cnt_0, 32'd3);
    chk("t1_pkt1", pkt_cnt_1, 32'd3);

    // Packet A stays on lane 0 through a stall; packet B goes to lane 1.
    send_beat(8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    send_beat(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready_0 = 1'b0;
    in_valid = 1'b1; in_data = 8'h12; in_sop = 1'b0; in_eop = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_hold", {23'd0, out_valid_0, out_data_0}, {23'd0, 1'b1, 8'h11});
    end
    @(posedge clk);
    #1;
    out_ready_0 = 1'b1;
    send_beat(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    send_beat(8'h13, 1'b0, 1'b1, 1'b0, 1'b0);
    send_beat(8'h20, 1'b1, 1'b0, 1'b1, 1'b1);
    send_beat(8'h21, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();
    chk("t2_pkt0", pkt_cnt_0, 32'd4);
    chk("t2_pkt1", pkt_cnt_1, 32'd4);

    // Fallback to lane 0 while lane 1 is stalled, then rr must still point at lane 1.
    out_ready_1 = 1'b0;
    send_beat(8'h30, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beat(8'h31, 1'b1, 1'b1, 1'b1, 1'b1);
    send_beat(8'h32, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beat(8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    out_ready_1 = 1'b1;
    send_beat(8'h34, 1'b1, 1'b1, 1'b1, 1'b1);

    // Both lanes full and stalled, then release lane 1 alone.
    out_ready_0 = 1'b0;
    out_ready_1 = 1'b0;
    send_beat(8'h40, 1'b1, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1; in_data = 8'h41; in_sop = 1'b1; in_eop = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("t4_both_full", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready_1 = 1'b1;
    send_beat(8'h41, 1'b1, 1'b1, 1'b1, 1'b1);
    out_ready_0 = 1'b1;
    drain();
    chk("t4_pkt0", pkt_cnt_0, 32'd8);
    chk("t4_pkt1", pkt_cnt_1, 32'd7);

    // Protocol violations: missing sop in IDLE, stray sop while LOCKED.
    send_beat(8'h50, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(8'h51, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t5_err", err_cnt, 32'd2);
    chk("t5_pkt0", pkt_cnt_0, 32'd9);

    // Reset in the middle of a packet while rr points at lane 1.
    send_beat(8'h5F, 1'b1, 1'b1, 1'b1, 1'b1);
    send_beat(8'h60, 1'b1, 1'b0, 1'b0, 1'b1);
    send_beat(8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("t6_rst_valid", {30'd0, out_valid_1, out_valid_0}, 32'd0);
    chk("t6_rst_data", {16'd0, out_data_1, out_data_0}, 32'd0);
    chk("t6_rst_delim", {28'd0, out_sop_1, out_eop_1, out_sop_0, out_eop_0}, 32'd0);
    chk("t6_rst_cnt", pkt_cnt_0 | pkt_cnt_1 | err_cnt, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_beat(8'h70, 1'b1, 1'b0, 1'b0, 1'b1);
    send_beat(8'h71, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();
    chk("t6_pkt0", pkt_cnt_0, 32'd1);
    chk("t6_pkt1", pkt_cnt_1, 32'd0);
    chk("t6_err", err_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
